// File: rtl/thresholding_cfg_pkg.sv
// Shared types and the padded config address layout for the thresholding config loader.
package thresholding_cfg_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        DUMP = 1'b1
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DUMP_ISSUE,
        ST_DUMP_DRAIN
    } state_e;

    // Address = {cf, pe, i}; a zero-width field contributes nothing.
    function automatic int unsigned cfg_addr(input int unsigned cf,
                                             input int unsigned pe,
                                             input int unsigned i,
                                             input int unsigned pe_bits,
                                             input int unsigned n_bits);
        return (cf << (pe_bits + n_bits)) | (pe << n_bits) | i;
    endfunction

endpackage

// File: rtl/cfg_rb_fifo.sv
// Readback FIFO: synchronous, first-word fall-through, exposes occupancy.
module cfg_rb_fifo #(
    parameter  int unsigned W     = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     din_i,
    input  logic             pop_i,
    output logic [W-1:0]     dout_o,
    output logic             vld_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && (cnt_q != CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign dout_o = mem_q[rd_q];
    assign vld_o  = (cnt_q != '0);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/thresholding_cfg_loader.sv
// Streams a dense channel-major threshold set into the thresholding cfg port (LOAD)
// or reads it back onto an output stream (DUMP), owning the padded address layout.
module thresholding_cfg_loader
    import thresholding_cfg_pkg::*;
#(
    parameter  int unsigned K        = 8,
    parameter  int unsigned N        = 3,
    parameter  int unsigned C        = 4,
    parameter  int unsigned PE       = 2,
    parameter  int unsigned RB_DEPTH = 8,
    localparam int unsigned CF       = C / PE,
    localparam int unsigned A_BITS   = $clog2(CF) + $clog2(PE) + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic              cmd_op,
    input  logic              ivld,
    output logic              irdy,
    input  logic [K-1:0]      idat,
    output logic              ovld,
    input  logic              ordy,
    output logic [K-1:0]      odat,
    output logic              cfg_en,
    output logic              cfg_we,
    output logic [A_BITS-1:0] cfg_a,
    output logic [K-1:0]      cfg_d,
    input  logic              cfg_rack,
    input  logic [K-1:0]      cfg_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CF_W    = (CF > 1) ? $clog2(CF) : 1;
    localparam int unsigned PE_W    = (PE > 1) ? $clog2(PE) : 1;
    localparam int unsigned I_W     = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PE_BITS = $clog2(PE);
    localparam int unsigned N_BITS  = $clog2(N);
    localparam int unsigned CNT_W   = $clog2(RB_DEPTH + 1);
    localparam int unsigned SUM_W   = CNT_W + 1;

    state_e             state_q;
    logic [I_W-1:0]     i_q;
    logic [PE_W-1:0]    pe_q;
    logic [CF_W-1:0]    cf_q;
    logic [CNT_W-1:0]   pend_q;
    logic [CNT_W-1:0]   pend_d;
    logic [CNT_W-1:0]   fcnt;
    logic               fin_q;
    logic               cmd_rdy_q;
    logic               irdy_q;
    logic               cfg_en_q;
    logic               cfg_we_q;
    logic [A_BITS-1:0]  cfg_a_q;
    logic [K-1:0]       cfg_d_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               accept_c;
    logic               wr_c;
    logic               rd_c;
    logic               last_c;
    logic               push_c;
    logic               pop_c;
    logic               room_c;
    logic               drained_c;
    logic [A_BITS-1:0]  addr_c;

    always_comb begin
        accept_c  = (state_q == ST_IDLE) && cmd_rdy_q && cmd_vld;
        wr_c      = (state_q == ST_LOAD) && irdy_q && ivld;
        // Reserve a FIFO slot for every outstanding read so racks never overflow it.
        room_c    = (SUM_W'(pend_q) + SUM_W'(fcnt)) < SUM_W'(RB_DEPTH);
        rd_c      = (state_q == ST_DUMP_ISSUE) && room_c;
        last_c    = (i_q == I_W'(N - 1)) && (pe_q == PE_W'(PE - 1)) && (cf_q == CF_W'(CF - 1));
        push_c    = cfg_rack && (pend_q != '0);
        pop_c     = ovld && ordy;
        pend_d    = pend_q + CNT_W'(rd_c) - CNT_W'(push_c);
        drained_c = (pend_q == '0) && ((fcnt == '0) || ((fcnt == CNT_W'(1)) && pop_c));
        addr_c    = A_BITS'(cfg_addr(32'(cf_q), 32'(pe_q), 32'(i_q), PE_BITS, N_BITS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            pe_q      <= '0;
            cf_q      <= '0;
            pend_q    <= '0;
            fin_q     <= 1'b0;
            cmd_rdy_q <= 1'b1;
            irdy_q    <= 1'b0;
            cfg_en_q  <= 1'b0;
            cfg_we_q  <= 1'b0;
            cfg_a_q   <= '0;
            cfg_d_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cfg_en_q <= 1'b0;
            cfg_we_q <= 1'b0;
            done_q   <= 1'b0;
            pend_q   <= pend_d;
            if (cfg_rack && (pend_q == '0)) err_q <= 1'b1;

            // LOAD completion is reported one cycle after the last write is presented.
            if (fin_q) begin
                fin_q     <= 1'b0;
                done_q    <= 1'b1;
                busy_q    <= 1'b0;
                cmd_rdy_q <= 1'b1;
            end

            if (wr_c || rd_c) begin
                cfg_en_q <= 1'b1;
                cfg_we_q <= wr_c;
                cfg_a_q  <= addr_c;
                cfg_d_q  <= wr_c ? idat : '0;
                if (i_q == I_W'(N - 1)) begin
                    i_q <= '0;
                    if (pe_q == PE_W'(PE - 1)) begin
                        pe_q <= '0;
                        cf_q <= (cf_q == CF_W'(CF - 1)) ? '0 : cf_q + CF_W'(1);
                    end else begin
                        pe_q <= pe_q + PE_W'(1);
                    end
                end else begin
                    i_q <= i_q + I_W'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        cmd_rdy_q <= 1'b0;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                        i_q       <= '0;
                        pe_q      <= '0;
                        cf_q      <= '0;
                        if (cmd_op_e'(cmd_op) == DUMP) begin
                            state_q <= ST_DUMP_ISSUE;
                        end else begin
                            state_q <= ST_LOAD;
                            irdy_q  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_c && last_c) begin
                        state_q <= ST_IDLE;
                        irdy_q  <= 1'b0;
                        fin_q   <= 1'b1;
                    end
                end
                ST_DUMP_ISSUE: begin
                    if (rd_c && last_c) state_q <= ST_DUMP_DRAIN;
                end
                ST_DUMP_DRAIN: begin
                    if (drained_c) begin
                        state_q   <= ST_IDLE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        cmd_rdy_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    cfg_rb_fifo #(
        .W     (K),
        .DEPTH (RB_DEPTH)
    ) u_rb_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_c),
        .din_i  (cfg_q),
        .pop_i  (pop_c),
        .dout_o (odat),
        .vld_o  (ovld),
        .cnt_o  (fcnt)
    );

    assign cmd_rdy = cmd_rdy_q;
    assign irdy    = irdy_q;
    assign cfg_en  = cfg_en_q;
    assign cfg_we  = cfg_we_q;
    assign cfg_a   = cfg_a_q;
    assign cfg_d   = cfg_d_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Bench for thresholding_cfg_loader: two configurations, each against a 3-cycle readback memory
// model, with queued expectations compared as cfg accesses and odat words appear.
module tb_thresholding_cfg_loader;
    import thresholding_cfg_pkg::*;

    localparam int unsigned AK = 8, AN = 3, AC = 4, APE = 2, ADEP = 4, AAB = 4;
    localparam int unsigned BK = 16, BN = 4, BC = 1, BPE = 1, BAB = 2;
    localparam int unsigned LAT = 3;

    typedef struct packed {
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
    } acc_t;

    typedef struct {
        logic [7:0] idat;
        logic [3:0] exp_a;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- instance A: K=8 N=3 C=4 PE=2 RB_DEPTH=4 ----------------
    logic           a_cmd_vld, a_cmd_rdy, a_cmd_op, a_ivld, a_irdy, a_ovld, a_ordy;
    logic [AK-1:0]  a_idat, a_odat, a_cfg_d, a_cfg_q;
    logic           a_cfg_en, a_cfg_we, a_cfg_rack, a_busy, a_done, a_err, a_rack_inj;
    logic [AAB-1:0] a_cfg_a;

    thresholding_cfg_loader #(.K(AK), .N(AN), .C(AC), .PE(APE), .RB_DEPTH(ADEP)) u_a (
        .clk(clk), .rst(rst), .cmd_vld(a_cmd_vld), .cmd_rdy(a_cmd_rdy), .cmd_op(a_cmd_op),
        .ivld(a_ivld), .irdy(a_irdy), .idat(a_idat), .ovld(a_ovld), .ordy(a_ordy), .odat(a_odat),
        .cfg_en(a_cfg_en), .cfg_we(a_cfg_we), .cfg_a(a_cfg_a), .cfg_d(a_cfg_d),
        .cfg_rack(a_cfg_rack), .cfg_q(a_cfg_q), .busy(a_busy), .done(a_done), .err(a_err)
    );

    logic [AK-1:0]  a_mem [16];
    logic [LAT-1:0] a_rv;
    logic [AK-1:0]  a_rd [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rv <= '0;
        end else begin
            a_rv    <= {a_rv[LAT-2:0], a_cfg_en && !a_cfg_we};
            a_rd[0] <= a_mem[a_cfg_a];
            a_rd[1] <= a_rd[0];
            a_rd[2] <= a_rd[1];
            if (a_cfg_en && a_cfg_we) a_mem[a_cfg_a] <= a_cfg_d;
        end
    end
    assign a_cfg_rack = a_rv[LAT-1] | a_rack_inj;
    assign a_cfg_q    = a_rd[LAT-1];

    acc_t       a_exp_q [$];
    logic [7:0] a_od_q [$];
    int         a_rd_cnt = 0;
    int         a_done_cnt = 0;
    acc_t       ae;
    logic [7:0] aod;

    always @(negedge clk) begin
        if (a_cfg_en) begin
            if (a_exp_q.size() == 0) begin
                chk("a_cfg_unexpected", 32'(a_cfg_a), 32'hFFFF_FFFF);
            end else begin
                ae = a_exp_q.pop_front();
                chk("a_cfg_we", 32'(a_cfg_we), 32'(ae.we));
                chk("a_cfg_a", 32'(a_cfg_a), 32'(ae.a));
                chk("a_cfg_d", 32'(a_cfg_d), 32'(ae.d));
            end
            if (!a_cfg_we) a_rd_cnt++;
        end
        if (a_ovld && a_ordy) begin
            if (a_od_q.size() == 0) begin
                chk("a_odat_unexpected", 32'(a_odat), 32'hFFFF_FFFF);
            end else begin
                aod = a_od_q.pop_front();
                chk("a_odat", 32'(a_odat), 32'(aod));
            end
        end
        if (a_done) a_done_cnt++;
    end

    // ---------------- instance B: K=16 N=4 C=PE=1 ----------------
    logic           b_cmd_vld, b_cmd_rdy, b_cmd_op, b_ivld, b_irdy, b_ovld, b_ordy;
    logic [BK-1:0]  b_idat, b_odat, b_cfg_d, b_cfg_q;
    logic           b_cfg_en, b_cfg_we, b_cfg_rack, b_busy, b_done, b_err;
    logic [BAB-1:0] b_cfg_a;

    thresholding_cfg_loader #(.K(BK), .N(BN), .C(BC), .PE(BPE)) u_b (
        .clk(clk), .rst(rst), .cmd_vld(b_cmd_vld), .cmd_rdy(b_cmd_rdy), .cmd_op(b_cmd_op),
        .ivld(b_ivld), .irdy(b_irdy), .idat(b_idat), .ovld(b_ovld), .ordy(b_ordy), .odat(b_odat),
        .cfg_en(b_cfg_en), .cfg_we(b_cfg_we), .cfg_a(b_cfg_a), .cfg_d(b_cfg_d),
        .cfg_rack(b_cfg_rack), .cfg_q(b_cfg_q), .busy(b_busy), .done(b_done), .err(b_err)
    );

    logic [BK-1:0]  b_mem [4];
    logic [LAT-1:0] b_rv;
    logic [BK-1:0]  b_rd [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            b_rv <= '0;
        end else begin
            b_rv    <= {b_rv[LAT-2:0], b_cfg_en && !b_cfg_we};
            b_rd[0] <= b_mem[b_cfg_a];
            b_rd[1] <= b_rd[0];
            b_rd[2] <= b_rd[1];
            if (b_cfg_en && b_cfg_we) b_mem[b_cfg_a] <= b_cfg_d;
        end
    end
    assign b_cfg_rack = b_rv[LAT-1];
    assign b_cfg_q    = b_rd[LAT-1];

    acc_t        b_exp_q [$];
    logic [15:0] b_od_q [$];
    int          b_done_cnt = 0;
    acc_t        be;
    logic [15:0] bod;

    always @(negedge clk) begin
        if (b_cfg_en) begin
            if (b_exp_q.size() == 0) begin
                chk("b_cfg_unexpected", 32'(b_cfg_a), 32'hFFFF_FFFF);
            end else begin
                be = b_exp_q.pop_front();
                chk("b_cfg_we", 32'(b_cfg_we), 32'(be.we));
                chk("b_cfg_a", 32'(b_cfg_a), 32'(be.a));
                chk("b_cfg_d", 32'(b_cfg_d), 32'(be.d));
            end
        end
        if (b_ovld && b_ordy) begin
            if (b_od_q.size() == 0) begin
                chk("b_odat_unexpected", 32'(b_odat), 32'hFFFF_FFFF);
            end else begin
                bod = b_od_q.pop_front();
                chk("b_odat", 32'(b_odat), 32'(bod));
            end
        end
        if (b_done) b_done_cnt++;
    end

    // ---------------- stimulus ----------------
    vec_t       tbl [12];
    logic [3:0] addrs [12];

    task automatic a_cmd(input logic op);
        int w;
        w = 0;
        @(negedge clk);
        a_cmd_vld = 1'b1;
        a_cmd_op  = op;
        while (!a_cmd_rdy && w < 50) begin @(negedge clk); w++; end
        chk("a_cmd_rdy_wait", 32'(a_cmd_rdy), 32'd1);
        @(posedge clk); #1;
        a_cmd_vld = 1'b0;
    endtask

    task automatic a_load(input int n);
        int w;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!a_irdy && w < 20) begin @(negedge clk); w++; end
            chk("a_irdy", 32'(a_irdy), 32'd1);
            a_ivld = 1'b1;
            a_idat = tbl[k].idat;
            a_exp_q.push_back('{1'b1, 16'(tbl[k].exp_a), 16'(tbl[k].idat)});
            @(posedge clk); #1;
        end
        a_ivld = 1'b0;
    endtask

    task automatic a_push_dump();
        for (int k = 0; k < 12; k++) begin
            a_exp_q.push_back('{1'b0, 16'(tbl[k].exp_a), 16'h0});
            a_od_q.push_back(tbl[k].idat);
        end
    endtask

    task automatic a_wait_done(input string nm, input int d0);
        int w;
        w = 0;
        while (!a_done && w < 400) begin @(posedge clk); #1; w++; end
        chk({nm, "_done"}, 32'(a_done), 32'd1);
        chk({nm, "_busy_at_done"}, 32'(a_busy), 32'd0);
        chk({nm, "_ovld_at_done"}, 32'(a_ovld), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_done_pulses"}, 32'(a_done_cnt - d0), 32'd1);
        chk({nm, "_cfg_left"}, 32'(a_exp_q.size()), 32'd0);
        chk({nm, "_odat_left"}, 32'(a_od_q.size()), 32'd0);
        chk({nm, "_err"}, 32'(a_err), 32'd0);
    endtask

    task automatic b_cmd(input logic op);
        int w;
        w = 0;
        @(negedge clk);
        b_cmd_vld = 1'b1;
        b_cmd_op  = op;
        while (!b_cmd_rdy && w < 50) begin @(negedge clk); w++; end
        chk("b_cmd_rdy_wait", 32'(b_cmd_rdy), 32'd1);
        @(posedge clk); #1;
        b_cmd_vld = 1'b0;
    endtask

    task automatic b_wait_done(input string nm, input int d0);
        int w;
        w = 0;
        while (!b_done && w < 400) begin @(posedge clk); #1; w++; end
        chk({nm, "_done"}, 32'(b_done), 32'd1);
        @(posedge clk); #1;
        chk({nm, "_done_pulses"}, 32'(b_done_cnt - d0), 32'd1);
        chk({nm, "_cfg_left"}, 32'(b_exp_q.size()), 32'd0);
        chk({nm, "_odat_left"}, 32'(b_od_q.size()), 32'd0);
        chk({nm, "_err"}, 32'(b_err), 32'd0);
    endtask

    initial begin
        int d0;
        int rd0;
        logic [15:0] bw;
        addrs = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14};
        for (int k = 0; k < 12; k++) tbl[k] = '{8'(8'h10 + k), addrs[k]};

        rst = 1'b1;
        a_cmd_vld = 1'b0; a_cmd_op = 1'b0; a_ivld = 1'b0; a_idat = '0; a_ordy = 1'b1; a_rack_inj = 1'b0;
        b_cmd_vld = 1'b0; b_cmd_op = 1'b0; b_ivld = 1'b0; b_idat = '0; b_ordy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_cmd_rdy", 32'(a_cmd_rdy), 32'd1);
        chk("rst_irdy", 32'(a_irdy), 32'd0);
        chk("rst_ovld", 32'(a_ovld), 32'd0);
        chk("rst_cfg_en", 32'(a_cfg_en), 32'd0);
        chk("rst_cfg_we", 32'(a_cfg_we), 32'd0);
        chk("rst_cfg_a", 32'(a_cfg_a), 32'd0);
        chk("rst_cfg_d", 32'(a_cfg_d), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_b_cmd_rdy", 32'(b_cmd_rdy), 32'd1);

        // LOAD with exact done timing: last accept t, last cfg t+1, done t+2
        d0 = a_done_cnt;
        a_cmd(LOAD);
        chk("load_busy", 32'(a_busy), 32'd1);
        a_load(12);
        chk("load_done_early", 32'(a_done), 32'd0);
        chk("load_busy_last_cfg", 32'(a_busy), 32'd1);
        @(posedge clk); #1;
        chk("load_done_t2", 32'(a_done), 32'd1);
        chk("load_busy_fall", 32'(a_busy), 32'd0);
        chk("load_cmd_rdy_rise", 32'(a_cmd_rdy), 32'd1);
        @(posedge clk); #1;
        chk("load_done_single", 32'(a_done), 32'd0);
        chk("load_done_pulses", 32'(a_done_cnt - d0), 32'd1);
        chk("load_cfg_left", 32'(a_exp_q.size()), 32'd0);

        // DUMP with ordy always high
        d0 = a_done_cnt;
        a_push_dump();
        a_cmd(DUMP);
        a_wait_done("dump1", d0);

        // DUMP with ordy stalled: only RB_DEPTH reads may be in flight
        d0 = a_done_cnt;
        a_ordy = 1'b0;
        rd0 = a_rd_cnt;
        a_push_dump();
        a_cmd(DUMP);
        repeat (20) @(negedge clk);
        chk("stall_reads", 32'(a_rd_cnt - rd0), 32'(ADEP));
        chk("stall_cfg_en", 32'(a_cfg_en), 32'd0);
        chk("stall_ovld", 32'(a_ovld), 32'd1);
        a_ordy = 1'b1;
        a_wait_done("dump_stall", d0);
        chk("stall_total_reads", 32'(a_rd_cnt - rd0), 32'd12);

        // Reset after 5 accepted LOAD words, then a clean LOAD from address 0
        d0 = a_done_cnt;
        a_cmd(LOAD);
        a_load(5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_cfg_en", 32'(a_cfg_en), 32'd0);
        chk("mid_rst_cmd_rdy", 32'(a_cmd_rdy), 32'd1);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_irdy", 32'(a_irdy), 32'd0);
        rst = 1'b0;
        chk("mid_rst_no_done", 32'(a_done_cnt - d0), 32'd0);
        d0 = a_done_cnt;
        a_cmd(LOAD);
        a_load(12);
        a_wait_done("reload", d0);

        // Rack with no read outstanding sets err and pushes nothing
        @(negedge clk);
        a_rack_inj = 1'b1;
        @(negedge clk);
        a_rack_inj = 1'b0;
        chk("stray_rack_err", 32'(a_err), 32'd1);
        chk("stray_rack_ovld", 32'(a_ovld), 32'd0);
        @(negedge clk);
        chk("stray_err_sticky", 32'(a_err), 32'd1);
        d0 = a_done_cnt;
        a_push_dump();
        a_cmd(DUMP);
        chk("err_clear_on_accept", 32'(a_err), 32'd0);
        a_wait_done("dump_after_err", d0);

        // Instance B: degenerate PE/CF, 16-bit data
        d0 = b_done_cnt;
        b_cmd(LOAD);
        for (int k = 0; k < 4; k++) begin
            chk("b_irdy", 32'(b_irdy), 32'd1);
            bw = 16'hA000 + 16'(k);
            b_ivld = 1'b1;
            b_idat = bw;
            b_exp_q.push_back('{1'b1, 16'(cfg_addr(0, 0, k, 0, 2)), bw});
            @(posedge clk); #1;
        end
        b_ivld = 1'b0;
        b_wait_done("b_load", d0);
        d0 = b_done_cnt;
        for (int k = 0; k < 4; k++) begin
            b_exp_q.push_back('{1'b0, 16'(cfg_addr(0, 0, k, 0, 2)), 16'h0});
            b_od_q.push_back(16'hA000 + 16'(k));
        end
        b_cmd(DUMP);
        b_wait_done("b_dump", d0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
